// File: rtl/mem_port_arbiter_pkg.sv
// Types shared by the unified memory-port arbiter and its request buffers.
// Latency: n/a (types only).  Backpressure: n/a.
// Request struct mirrors the shared memory port so buffers and output registers share one layout.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_BUSY_I = 2'b01,
        ARB_BUSY_D = 2'b10
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_NONE = '0;

endpackage

// File: rtl/mem_port_arbiter_req_buffer.sv
// One-entry pending holder for a single requester's memory request.
// Latency: loaded entry visible the cycle after the load pulse.
// Backpressure: none; the requester keeps at most one request in flight, so a load never overwrites a live entry.
module mem_port_arbiter_req_buffer
    import mem_port_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  mem_req_t load_dat,
    input  logic     clear,
    input  logic     flush,
    output logic     pend_vld,
    output mem_req_t pend_dat
);

    // Clear means the entry (or its same-cycle bypass) was issued at this edge.
    // A load beats a flush: the flush only discards requests older than this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_dat <= MEM_REQ_NONE;
        end else begin
            if (clear) begin
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_vld <= 1'b1;
            end else if (flush) begin
                pend_vld <= 1'b0;
            end

            if (load && !clear) begin
                pend_dat <= load_dat;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (imem) and load/store (dmem), one access outstanding.
// Latency: mem request registered one cycle after the request pulse; response steered back combinationally.
// Backpressure: none upstream; requests wait in one-entry buffers while the port is busy.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit PRIO_DMEM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    input  logic        imem_flush,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t state, next_state;
    grant_t     last_grant;
    logic       squash;
    mem_req_t   mem_req_q;

    mem_req_t   imem_in, dmem_in;
    logic       imem_pulse, dmem_pulse;
    logic       i_pend_vld, d_pend_vld;
    mem_req_t   i_pend_dat, d_pend_dat;
    logic       cand_i_vld, cand_d_vld;
    mem_req_t   cand_i_dat, cand_d_dat;
    logic       port_free, issue, pick_d;
    logic       issue_i, issue_d;
    mem_req_t   sel_req;

    assign imem_in    = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
    assign dmem_in    = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
    assign imem_pulse = |imem_rmask;
    assign dmem_pulse = |(dmem_rmask | dmem_wmask);

    mem_port_arbiter_req_buffer u_imem_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (imem_pulse),
        .load_dat (imem_in),
        .clear    (issue_i),
        .flush    (imem_flush),
        .pend_vld (i_pend_vld),
        .pend_dat (i_pend_dat)
    );

    mem_port_arbiter_req_buffer u_dmem_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dmem_pulse),
        .load_dat (dmem_in),
        .clear    (issue_d),
        .flush    (1'b0),
        .pend_vld (d_pend_vld),
        .pend_dat (d_pend_dat)
    );

    // Candidates include same-cycle pulses so an idle port issues without an extra buffer cycle.
    assign cand_i_vld = imem_pulse | (i_pend_vld & ~imem_flush);
    assign cand_i_dat = imem_pulse ? imem_in : i_pend_dat;
    assign cand_d_vld = dmem_pulse | d_pend_vld;
    assign cand_d_dat = dmem_pulse ? dmem_in : d_pend_dat;

    // In IDLE the port is free regardless of mem_resp, so a stale response is harmless.
    assign port_free = (state == ARB_IDLE) || mem_resp;

    always_comb begin
        pick_d = cand_d_vld;
        if (cand_i_vld && cand_d_vld) begin
            pick_d = PRIO_DMEM ? 1'b1 : (last_grant == GRANT_I);
        end
    end

    assign issue   = port_free && (cand_i_vld || cand_d_vld);
    assign issue_i = issue && !pick_d;
    assign issue_d = issue && pick_d;
    assign sel_req = pick_d ? cand_d_dat : cand_i_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (issue) begin
                    next_state = pick_d ? ARB_BUSY_D : ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_resp) begin
                    if (issue) begin
                        next_state = pick_d ? ARB_BUSY_D : ARB_BUSY_I;
                    end else begin
                        next_state = ARB_IDLE;
                    end
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // A flush coincident with the fetch response suppresses it directly, not via squash.
    always_comb begin
        imem_resp  = (state == ARB_BUSY_I) && mem_resp && !squash && !imem_flush;
        dmem_resp  = (state == ARB_BUSY_D) && mem_resp;
        imem_rdata = mem_rdata;
        dmem_rdata = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q <= MEM_REQ_NONE;
        end else if (issue) begin
            mem_req_q <= sel_req;
        end else begin
            mem_req_q.rmask <= 4'h0;
            mem_req_q.wmask <= 4'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_I;
        end else if (issue) begin
            last_grant <= pick_d ? GRANT_D : GRANT_I;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash <= 1'b0;
        end else if ((state != ARB_IDLE) && mem_resp) begin
            squash <= 1'b0;
        end else if ((state == ARB_BUSY_I) && imem_flush) begin
            squash <= 1'b1;
        end
    end

    assign mem_addr  = mem_req_q.addr;
    assign mem_rmask = mem_req_q.rmask;
    assign mem_wmask = mem_req_q.wmask;
    assign mem_wdata = mem_req_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (dmem priority and round-robin) with shared stimulus; a queue-based reference
// model predicts each mem request and each requester response, and a negedge monitor compares them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic        imem_flush = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;

    logic [31:0] imem_rdata [2];
    logic        imem_resp  [2];
    logic [31:0] dmem_rdata [2];
    logic        dmem_resp  [2];
    logic [31:0] mem_addr   [2];
    logic [3:0]  mem_rmask  [2];
    logic [3:0]  mem_wmask  [2];
    logic [31:0] mem_wdata  [2];
    logic [31:0] mem_rdata  [2];
    logic        mem_resp   [2];

    mem_port_arbiter #(.PRIO_DMEM(1'b1)) u_prio (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_flush(imem_flush),
        .imem_rdata(imem_rdata[0]), .imem_resp(imem_resp[0]),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata[0]), .dmem_resp(dmem_resp[0]),
        .mem_addr(mem_addr[0]), .mem_rmask(mem_rmask[0]), .mem_wmask(mem_wmask[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0])
    );

    mem_port_arbiter #(.PRIO_DMEM(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_flush(imem_flush),
        .imem_rdata(imem_rdata[1]), .imem_resp(imem_resp[1]),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata[1]), .dmem_resp(dmem_resp[1]),
        .mem_addr(mem_addr[1]), .mem_rmask(mem_rmask[1]), .mem_wmask(mem_wmask[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1])
    );

    typedef struct { int cyc; mem_req_t r; } exp_req_t;
    typedef struct { int cyc; logic [31:0] d; } exp_rsp_t;

    exp_req_t req_q [2][$];
    exp_rsp_t iq    [2][$];
    exp_rsp_t dq    [2][$];

    // Reference model per instance: owner 0=none 1=imem 2=dmem.
    int       own   [2];
    int       rcyc  [2];
    bit       sq    [2];
    bit       ipv   [2];
    bit       dpv   [2];
    mem_req_t ipr   [2];
    mem_req_t dpr   [2];
    int       lg    [2];
    bit       ilive [2];
    bit       dlive [2];

    int          force_delay = 0;
    bit          fix_rd = 1'b0;
    logic [31:0] fixed_rd = '0;
    bit          stray_en = 1'b0;
    bit          force_stray = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; rcyc[k] = 0; sq[k] = 0; ipv[k] = 0; dpv[k] = 0;
            ipr[k] = '0; dpr[k] = '0; lg[k] = 1; ilive[k] = 0; dlive[k] = 0;
            req_q[k].delete(); iq[k].delete(); dq[k].delete();
        end
    endtask

    function automatic bit i_free(input int k);
        return !ilive[k] || (own[k] == 1 && !sq[k] && rcyc[k] == cyc);
    endfunction

    function automatic bit d_free(input int k);
        return !dlive[k] || (own[k] == 2 && rcyc[k] == cyc);
    endfunction

    task automatic model_cycle(input int k, input bit ip, input logic [31:0] ia, input bit fl,
                               input int dop, input mem_req_t dreq);
        bit          resp;
        logic [31:0] rd;
        int          pick;
        mem_req_t    nreq;
        rd = fix_rd ? fixed_rd : $urandom;
        if (own[k] != 0) resp = (rcyc[k] == cyc);
        else             resp = force_stray || (stray_en && $urandom_range(0, 7) == 0);
        mem_resp[k]  = resp;
        mem_rdata[k] = rd;

        if (resp && own[k] == 1) begin
            if (!sq[k] && !fl) iq[k].push_back('{cyc, rd});
            if (!sq[k]) ilive[k] = 0;
        end
        if (resp && own[k] == 2) begin
            dq[k].push_back('{cyc, rd});
            dlive[k] = 0;
        end
        if (fl) begin
            ipv[k] = 0; ilive[k] = 0;
            if (own[k] == 1) sq[k] = 1;
        end
        if (ip) begin
            ipv[k] = 1; ipr[k] = '{ia, 4'hF, 4'h0, 32'h0}; ilive[k] = 1;
        end
        if (dop != 0) begin
            dpv[k] = 1; dpr[k] = dreq; dlive[k] = 1;
        end

        if (own[k] == 0 || resp) begin
            own[k] = 0;
            pick = 0;
            if (ipv[k] && dpv[k]) pick = (k == 0) ? 2 : ((lg[k] == 1) ? 2 : 1);
            else if (dpv[k])      pick = 2;
            else if (ipv[k])      pick = 1;
            if (pick != 0) begin
                nreq = (pick == 2) ? dpr[k] : ipr[k];
                req_q[k].push_back('{cyc + 1, nreq});
                if (pick == 2) dpv[k] = 0; else ipv[k] = 0;
                lg[k] = pick; own[k] = pick; sq[k] = 0;
                rcyc[k] = cyc + 1 + ((force_delay != 0) ? force_delay : int'($urandom_range(1, 3)));
            end
        end
    endtask

    task automatic step(input bit ip, input logic [31:0] ia, input bit fl, input int dop,
                        input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dw);
        mem_req_t dreq;
        assert (fl || !ip || (i_free(0) && i_free(1)))
            else $error("illegal stimulus: imem pulse with previous fetch unanswered");
        assert (dop == 0 || (d_free(0) && d_free(1)))
            else $error("illegal stimulus: dmem pulse with previous access unanswered");
        imem_rmask = ip ? 4'hF : 4'h0;
        imem_addr  = ip ? ia : $urandom;
        imem_flush = fl;
        dmem_rmask = (dop == 1) ? dm : 4'h0;
        dmem_wmask = (dop == 2) ? dm : 4'h0;
        dmem_addr  = (dop != 0) ? da : $urandom;
        dmem_wdata = dw;
        assert (!((dmem_rmask != 4'h0) && (dmem_wmask != 4'h0)))
            else $error("illegal stimulus: dmem read and write in one pulse");
        dreq = '{dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata};
        for (int k = 0; k < 2; k++) model_cycle(k, ip, imem_addr, fl, dop, dreq);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 32'h0, 4'h0, $urandom);
    endtask

    task automatic check_inst(input int k);
        bit       e_vld, g_vld;
        exp_req_t er;
        exp_rsp_t es;
        e_vld = req_q[k].size() != 0 && req_q[k][0].cyc == cyc;
        g_vld = (mem_rmask[k] | mem_wmask[k]) != 4'h0;
        n_cmp++;
        if (e_vld != g_vld) begin
            n_bad++;
            $display("FAIL mem_req_issue inst%0d cyc %0d: got %0b want %0b", k, cyc, g_vld, e_vld);
        end
        if (e_vld) begin
            er = req_q[k].pop_front();
            if (g_vld) begin
                n_cmp++;
                if ({mem_addr[k], mem_rmask[k], mem_wmask[k], mem_wdata[k]} != er.r) begin
                    n_bad++;
                    $display("FAIL mem_req_fields inst%0d cyc %0d: got %h want %h", k, cyc,
                             {mem_addr[k], mem_rmask[k], mem_wmask[k], mem_wdata[k]}, er.r);
                end
            end
        end

        e_vld = iq[k].size() != 0 && iq[k][0].cyc == cyc;
        n_cmp++;
        if (e_vld != imem_resp[k]) begin
            n_bad++;
            $display("FAIL imem_resp inst%0d cyc %0d: got %0b want %0b", k, cyc, imem_resp[k], e_vld);
        end
        if (e_vld) begin
            es = iq[k].pop_front();
            n_cmp++;
            if (imem_rdata[k] != es.d) begin
                n_bad++;
                $display("FAIL imem_rdata inst%0d cyc %0d: got %h want %h", k, cyc, imem_rdata[k], es.d);
            end
        end

        e_vld = dq[k].size() != 0 && dq[k][0].cyc == cyc;
        n_cmp++;
        if (e_vld != dmem_resp[k]) begin
            n_bad++;
            $display("FAIL dmem_resp inst%0d cyc %0d: got %0b want %0b", k, cyc, dmem_resp[k], e_vld);
        end
        if (e_vld) begin
            es = dq[k].pop_front();
            n_cmp++;
            if (dmem_rdata[k] != es.d) begin
                n_bad++;
                $display("FAIL dmem_rdata inst%0d cyc %0d: got %h want %h", k, cyc, dmem_rdata[k], es.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) check_inst(k);
        end
    end

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({mem_addr[k], mem_rmask[k], mem_wmask[k], mem_wdata[k]} != 72'h0) begin
                n_bad++;
                $display("FAIL reset_mem_regs inst%0d: got %h want 0", k,
                         {mem_addr[k], mem_rmask[k], mem_wmask[k], mem_wdata[k]});
            end
            n_cmp++;
            if ({imem_resp[k], dmem_resp[k]} != 2'b00) begin
                n_bad++;
                $display("FAIL reset_resp inst%0d: got %b want 00", k, {imem_resp[k], dmem_resp[k]});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_resp[0] = 1'b0; mem_resp[1] = 1'b0;
        mem_rdata[0] = '0;  mem_rdata[1] = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Lone fetch: request visible one cycle later, response three cycles after that.
        force_delay = 3; fix_rd = 1'b1; fixed_rd = 32'h0000_0013;
        step(1, 32'h1eceb000, 0, 0, 32'h0, 4'h0, 32'h0);
        idle(5);
        fix_rd = 1'b0;

        // Simultaneous fetch and store.
        force_delay = 2;
        step(1, 32'h1eceb004, 0, 2, 32'h1eceb100, 4'h3, 32'hdeadbeef);
        idle(8);

        // Round-robin: last grant dmem, then last grant imem, each followed by a tie.
        step(0, 32'h0, 0, 1, 32'h1eceb110, 4'hF, 32'h0);
        idle(4);
        step(1, 32'h1eceb00c, 0, 1, 32'h1eceb114, 4'hF, 32'h0);
        idle(8);
        step(1, 32'h1eceb010, 0, 0, 32'h0, 4'h0, 32'h0);
        idle(4);
        step(1, 32'h1eceb014, 0, 1, 32'h1eceb118, 4'hF, 32'h0);
        idle(8);

        // Flush while the fetch is in flight, with a new fetch pulsed alongside it.
        force_delay = 4;
        step(1, 32'h1eceb008, 0, 0, 32'h0, 4'h0, 32'h0);
        idle(1);
        step(1, 32'h1eceb200, 1, 0, 32'h0, 4'h0, 32'h0);
        idle(10);

        // Load arrives during a fetch and must issue right after the fetch response.
        force_delay = 3;
        step(1, 32'h1eceb020, 0, 0, 32'h0, 4'h0, 32'h0);
        step(0, 32'h0, 0, 1, 32'h1eceb120, 4'hF, 32'h0);
        idle(8);

        // New fetch in the same cycle as its own previous response.
        force_delay = 2;
        step(1, 32'h1eceb024, 0, 0, 32'h0, 4'h0, 32'h0);
        idle(2);
        step(1, 32'h1eceb028, 0, 0, 32'h0, 4'h0, 32'h0);
        idle(6);

        force_delay = 0;
        stray_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit fl, ip;
            int dop;
            fl  = ($urandom_range(0, 11) == 0);
            ip  = (fl || (i_free(0) && i_free(1))) && ($urandom_range(0, 2) != 0);
            dop = (d_free(0) && d_free(1)) ? int'($urandom_range(0, 2)) : 0;
            step(ip, $urandom, fl, dop, $urandom, 4'($urandom_range(1, 15)), $urandom);
        end
        stray_en = 1'b0;
        idle(12);

        // Asynchronous reset during a load, then a stray response into IDLE.
        force_delay = 6;
        step(0, 32'h0, 0, 1, 32'h1eceb300, 4'hF, 32'h0);
        idle(2);
        imem_rmask = 4'h0; imem_flush = 1'b0; dmem_rmask = 4'h0; dmem_wmask = 4'h0;
        mem_resp[0] = 1'b0; mem_resp[1] = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        force_stray = 1'b1;
        idle(1);
        force_stray = 1'b0;
        idle(2);
        force_delay = 1;
        step(1, 32'h1eceb400, 0, 0, 32'h0, 4'h0, 32'h0);
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
